btn_evt: RTL

//  Converts debounced button levels (output of the debouncer) into one-clock
//  key events: press, short-press release, long-press, auto-repeat. Sits

---
 rtl/btn_evt_pkg.sv | 12 +
 rtl/btn_evt_fsm.sv | 98 +++++++++
 rtl/btn_evt.sv | 64 ++++++
 3 files changed

// File: rtl/btn_evt_pkg.sv
// Shared types and widths for the button event block.
package btn_evt_pkg;

  localparam int unsigned MS_CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRESS = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/btn_evt_fsm.sv
// Per-button event FSM: press / short release / long hold / auto-repeat pulses.
module btn_evt_fsm
  import btn_evt_pkg::*;
#(
  parameter int unsigned LONG_MS = 1000,
  parameter int unsigned REP_MS  = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic ms_tick,
  input  logic pressed,
  output logic press_p,
  output logic short_p,
  output logic long_p,
  output logic rep_p,
  output logic held
);

  localparam logic [MS_CNT_W-1:0] LONG_LAST = MS_CNT_W'(LONG_MS - 1);
  localparam logic [MS_CNT_W-1:0] REP_LAST  = MS_CNT_W'(REP_MS - 1);

  state_t              state, state_n;
  logic [MS_CNT_W-1:0] cnt, cnt_n;
  logic                press_n, short_n, long_n, rep_n, held_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      press_p <= 1'b0;
      short_p <= 1'b0;
      long_p  <= 1'b0;
      rep_p   <= 1'b0;
      held    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      press_p <= press_n;
      short_p <= short_n;
      long_p  <= long_n;
      rep_p   <= rep_n;
      held    <= held_n;
    end
  end

  // Release is tested before the tick so it wins over a coincident threshold.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    press_n = 1'b0;
    short_n = 1'b0;
    long_n  = 1'b0;
    rep_n   = 1'b0;
    case (state)
      S_IDLE: begin
        if (pressed) begin
          state_n = S_PRESS;
          cnt_n   = '0;
          press_n = 1'b1;
        end
      end
      S_PRESS: begin
        if (!pressed) begin
          state_n = S_IDLE;
          cnt_n   = '0;
          short_n = 1'b1;
        end else if (ms_tick) begin
          if (cnt == LONG_LAST) begin
            state_n = S_HOLD;
            cnt_n   = '0;
            long_n  = 1'b1;
          end else begin
            cnt_n = cnt + MS_CNT_W'(1);
          end
        end
      end
      S_HOLD: begin
        if (!pressed) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else if (ms_tick) begin
          if (cnt == REP_LAST) begin
            cnt_n = '0;
            rep_n = 1'b1;
          end else begin
            cnt_n = cnt + MS_CNT_W'(1);
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
    held_n = (state_n == S_PRESS) || (state_n == S_HOLD);
  end

endmodule

// File: rtl/btn_evt.sv
// Button event generator: shared 1 ms prescaler, input register, one FSM per button.
module btn_evt
  import btn_evt_pkg::*;
#(
  parameter int unsigned BT_WIDTH   = 8,
  parameter int unsigned CLK_FRE    = 50_000_000,
  parameter int unsigned LONG_MS    = 1000,
  parameter int unsigned REP_MS     = 200,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BT_WIDTH-1:0] btn_in,
  output logic [BT_WIDTH-1:0] press_p,
  output logic [BT_WIDTH-1:0] short_p,
  output logic [BT_WIDTH-1:0] long_p,
  output logic [BT_WIDTH-1:0] rep_p,
  output logic [BT_WIDTH-1:0] held
);

  localparam int unsigned         DIV     = CLK_FRE / 1000;
  localparam int unsigned         PRE_W   = $clog2(DIV);
  localparam logic [PRE_W-1:0]    PRE_MAX = PRE_W'(DIV - 1);
  localparam logic [BT_WIDTH-1:0] RELEASED = ACTIVE_LOW ? {BT_WIDTH{1'b1}} : {BT_WIDTH{1'b0}};

  logic [PRE_W-1:0]    pre;
  logic                ms_tick;
  logic [BT_WIDTH-1:0] btn_q;
  logic [BT_WIDTH-1:0] pressed;

  // Free-running prescaler; never re-aligned to button activity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          pre <= '0;
    else if (ms_tick) pre <= '0;
    else              pre <= pre + PRE_W'(1);
  end

  assign ms_tick = (pre == PRE_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) btn_q <= RELEASED;
    else     btn_q <= btn_in;
  end

  assign pressed = ACTIVE_LOW ? ~btn_q : btn_q;

  for (genvar i = 0; i < BT_WIDTH; i++) begin : g_btn
    btn_evt_fsm #(
      .LONG_MS (LONG_MS),
      .REP_MS  (REP_MS)
    ) u_fsm (
      .clk     (clk),
      .rst     (rst),
      .ms_tick (ms_tick),
      .pressed (pressed[i]),
      .press_p (press_p[i]),
      .short_p (short_p[i]),
      .long_p  (long_p[i]),
      .rep_p   (rep_p[i]),
      .held    (held[i])
    );
  end

endmodule
